ball_multi_engine: RTL
======================

# ball_multi_engine

Parametrised multi-ball motion and render engine; successor to the single-ball bouncing demo. Keeps N_BALLS independent square sprites, advances all of them once per frame with a small sequential update FSM in the pixel-clock domain (no logic clocked by vsync), clamps and reflects at the screen edges, counts wall bounces and produces registered 3-bit RGB. Sits between the hvsync generator and the VGA pins in the 25 MHz pixel domain.

## Interface

- N_BALLS, 4: number of balls, 1..16
- BALL_SIZE, 4: ball edge length in pixels, 1..32
- H_ACTIVE, 640: visible width; must be ≤ 1023
- V_ACTIVE, 480: visible height; must be ≤ 1023
- SPEED, 2: pixels moved per axis per frame, 1..BALL_SIZE
- Reset: one clock; reset is asynchronous and active-low (`res` asserts reset at 0).

- clk  in  1  pixel clock (25 MHz)
- res  in  1  async active-low reset
- hpos  in  10  beam X from hvsync generator
- vpos  in  10  beam Y from hvsync generator
- display_on  in  1  beam in visible area
- hsync_in  in  1  hsync from generator
- vsync_in  in  1  vsync from generator (active-high)
- stop  in  1  freeze motion while high
- hsync  out  1  hsync_in delayed 1 clk
- vsync  out  1  vsync_in delayed 1 clk
- rgb  out  3  {b,g,r}, registered
- busy  out  1  update FSM active
- bounce_count  out  8  wall bounces since reset, wraps
- ball_pos  out  N_BALLS*20  {v[9:0],h[9:0]} per ball, ball i at bits [20i+19:20i]

## Operation

- Initial state of ball i: h = H_ACTIVE/2 − BALL_SIZE + 16·i, v = V_ACTIVE/2 − BALL_SIZE; dir_h = right if i even else left; dir_v = down if (i mod 4) < 2 else up.
- Frame tick: rising edge of vsync_in, via a registered copy (tick = vsync_in & ~vsync_q).
- FSM: IDLE → UPDATE on tick when stop = 0 (stop sampled on the tick cycle only); idx = 0. UPDATE processes ball idx in one clk, idx++; after idx = N_BALLS−1 → IDLE. Tick while in UPDATE is ignored.
- Per-axis update (shown for h; v uses V_ACTIVE):
  - right: if h + SPEED ≥ H_ACTIVE − BALL_SIZE → h = H_ACTIVE − BALL_SIZE, dir = left, bounce; else h += SPEED.
  - left: if h ≤ SPEED → h = 0, dir = right, bounce; else h −= SPEED.
  - Comparisons on 11-bit unsigned; no wrap of position is ever possible.
- bounce_count += number of axes that bounced in that cycle (0, 1 or 2), mod 256.
- Render: ball i hit when (hpos − h_i) mod 1024 < BALL_SIZE and (vpos − v_i) mod 1024 < BALL_SIZE. Ball colour = ((i mod 7) + 1). Overlap: lowest index wins. No ball: grid colour 3'b010 when hpos[2:0] = 0 and vpos[2:0] = 0, else 0. display_on = 0 forces 0.

## Timing

- Reset values: rgb = 0, hsync = 0, vsync = 0, busy = 0, bounce_count = 0, state IDLE, idx = 0, vsync_q = 0, all balls at initial state.
- Tick detected one clk after vsync_in rises; busy high from the following clk for exactly N_BALLS clks.
- Ball i position visible on ball_pos 2 + i clks after the vsync_in rising edge.
- Updates happen inside vertical blanking; no tearing within the visible frame.
- rgb, hsync, vsync: 1 clk latency from hpos/vpos/display_on/sync inputs; mutually aligned.
- Reset asserted mid-UPDATE: immediate return to IDLE and initial positions; partial frame discarded.
- stop rising during UPDATE does not abort the current pass.

## Test plan

- Reset with defaults → ball0 = (316,236), ball1 = (332,236), ball2 = (348,236) dir_v up, rgb = 0, bounce_count = 0, busy = 0.
- One vsync rising edge → busy high 4 clks; ball0 = (318,238), ball1 = (330,238), ball2 = (350,234), ball3 = (362,234).
- 120 frames → ball0 v = 476 (clamped), dir_v up, bounce_count ≥ 1; frame 121 → v = 474. 160 frames → ball0 h = 636, dir_h left.
- SPEED = 3, ball at h = 2 moving left → next frame h = 0, dir right, bounce_count +1; following frame h = 3.
- stop = 1 across 5 vsync edges → ball_pos unchanged, busy never high; stop = 0 → motion resumes from the same positions.
- Beam at ball0 origin (316,236), display_on = 1 → rgb = 3'b001 one clk later; overlap of ball0/ball1 → 3'b001; (320,240) with no ball → 3'b010; display_on = 0 → 3'b000; res pulse low mid-UPDATE → all balls back to initial values.

Source files
------------

// File: rtl/ball_multi_engine.sv
// ball_multi_engine: N independent bouncing square sprites, updated once per frame by a
// sequential pixel-clock FSM, rendered to registered 3-bit RGB with 1-clk aligned syncs.
module ball_multi_engine #(
  parameter int N_BALLS   = 4,
  parameter int BALL_SIZE = 4,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int SPEED     = 2
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic [9:0]           hpos,
  input  logic [9:0]           vpos,
  input  logic                 display_on,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic                 stop,
  output logic                 hsync,
  output logic                 vsync,
  output logic [2:0]           rgb,
  output logic                 busy,
  output logic [7:0]           bounce_count,
  output logic [N_BALLS*20-1:0] ball_pos
);
  localparam int IW = N_BALLS > 1 ? $clog2(N_BALLS) : 1;
  typedef enum logic {IDLE, UPDATE} state_t;
  state_t state, next;
  logic [IW-1:0] idx;
  logic vsync_q, tick, last;
  logic [9:0] h [N_BALLS];
  logic [9:0] v [N_BALLS];
  logic dir_h [N_BALLS];
  logic dir_v [N_BALLS];
  logic [11:0] sh, sv;
  logic [2:0] color;
  logic [N_BALLS-1:0] hit;
  // Result packs {bounced, forward_dir, new_pos}; forward means right/down.
  function automatic logic [11:0] step(input logic [9:0] p, input logic d, input int lim);
    logic [10:0] q;
    q = {1'b0, p};
    if (d) step = (q + 11'(SPEED) >= 11'(lim - BALL_SIZE)) ? {2'b10, 10'(lim - BALL_SIZE)} : {2'b01, p + 10'(SPEED)};
    else step = (q <= 11'(SPEED)) ? {2'b11, 10'd0} : {2'b00, p - 10'(SPEED)};
  endfunction
  assign tick = vsync_in & ~vsync_q;
  assign busy = state == UPDATE;
  assign last = idx == IW'(N_BALLS - 1);
  assign sh = step(h[idx], dir_h[idx], H_ACTIVE);
  assign sv = step(v[idx], dir_v[idx], V_ACTIVE);
  always_comb begin
    next = state;
    next = (state == IDLE) ? ((tick && !stop) ? UPDATE : IDLE) : (last ? IDLE : UPDATE);
  end
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state   <= IDLE;
      vsync_q <= 1'b0;
      hsync   <= 1'b0;
      vsync   <= 1'b0;
      rgb     <= 3'b000;
    end else begin
      state   <= next;
      vsync_q <= vsync_in;
      hsync   <= hsync_in;
      vsync   <= vsync_in;
      rgb     <= display_on ? color : 3'b000;
    end
  end
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      idx          <= '0;
      bounce_count <= '0;
      for (int i = 0; i < N_BALLS; i++) begin
        h[i]     <= 10'(H_ACTIVE / 2 - BALL_SIZE + 16 * i);
        v[i]     <= 10'(V_ACTIVE / 2 - BALL_SIZE);
        dir_h[i] <= (i % 2) == 0;
        dir_v[i] <= (i % 4) < 2;
      end
    end else if (state == UPDATE) begin
      h[idx]       <= sh[9:0];
      dir_h[idx]   <= sh[10];
      v[idx]       <= sv[9:0];
      dir_v[idx]   <= sv[10];
      bounce_count <= bounce_count + 8'(sh[11]) + 8'(sv[11]);
      idx          <= last ? '0 : idx + 1'b1;
    end
  end
  for (genvar i = 0; i < N_BALLS; i++) begin : g_ball
    logic [9:0] dh, dv;
    assign dh = hpos - h[i];
    assign dv = vpos - v[i];
    assign hit[i] = (dh < 10'(BALL_SIZE)) && (dv < 10'(BALL_SIZE));
    assign ball_pos[20*i +: 20] = {v[i], h[i]};
  end
  // Scan from the top index down so the lowest-index ball ends up on top.
  always_comb begin
    color = (hpos[2:0] == 3'd0 && vpos[2:0] == 3'd0) ? 3'b010 : 3'b000;
    for (int i = N_BALLS - 1; i >= 0; i--)
      if (hit[i]) color = 3'(i % 7 + 1);
  end
endmodule
